// File: rtl/sram_access_controller.sv
// Moves each MEM-stage 32-bit access over a 16-bit fixed-wait-state SRAM as two halfword
// transactions (low half, then high half) and drives 'ready', whose inverse freezes the pipeline.
module sram_access_controller #(
    parameter int WAIT_CYCLES = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read_en,
    input  logic        mem_write_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic [17:0] sram_addr,
    output logic [15:0] sram_dq_out,
    output logic        sram_dq_oe,
    input  logic [15:0] sram_dq_in,
    output logic        sram_we_n
);

    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

    state_t     state;
    logic [3:0] cnt;
    logic       op_write;
    logic       req;
    logic       last;
    logic       active;
    logic       half;
    logic       unused_addr_bits;

    assign req    = mem_read_en | mem_write_en;
    assign last   = (cnt == LAST_CNT);
    assign active = (state == LOW) || (state == HIGH);
    assign half   = (state == HIGH);

    // Only bits [18:2] select a word; the rest of the byte address is ignored.
    assign unused_addr_bits = ^{address[31:19], address[1:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            op_write  <= 1'b0;
            read_data <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        state    <= LOW;
                        cnt      <= 4'd0;
                        op_write <= mem_write_en;
                    end
                end
                LOW: begin
                    if (last) begin
                        state <= HIGH;
                        cnt   <= 4'd0;
                        if (!op_write) read_data[15:0] <= sram_dq_in;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                HIGH: begin
                    if (last) begin
                        state <= DONE;
                        cnt   <= 4'd0;
                        if (!op_write) read_data[31:16] <= sram_dq_in;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 4'd0;
                end
            endcase
        end
    end

    // SRAM pins decode directly from the registered state so reset clears them asynchronously.
    always_comb begin
        ready       = ((state == IDLE) && !req) || (state == DONE);
        sram_addr   = 18'd0;
        sram_dq_oe  = 1'b0;
        sram_dq_out = 16'd0;
        sram_we_n   = 1'b1;
        if (active) begin
            sram_addr = {address[18:2], half};
            if (op_write) begin
                sram_dq_oe  = 1'b1;
                sram_dq_out = half ? write_data[31:16] : write_data[15:0];
                sram_we_n   = last;
            end
        end
    end

endmodule
